// File: rtl/inst_fetch.sv
// Instruction fetch unit: owns the PC, runs a req/ack read of instruction memory and
// hands one instruction at a time to decode, with branch flush and halt support.
module inst_fetch #(
    parameter int INST_ADDR_WIDTH = 16,
    parameter int INST_WIDTH      = 16,
    parameter logic [INST_ADDR_WIDTH-1:0] RESET_PC = '0
) (
    input  logic                       clk,
    input  logic                       rst_n,
    output logic [INST_ADDR_WIDTH-1:0] pc_out,
    input  logic [INST_ADDR_WIDTH-1:0] pc_next,
    input  logic                       flush,
    input  logic                       halt,
    output logic                       imem_req,
    output logic [INST_ADDR_WIDTH-1:0] imem_addr,
    input  logic                       imem_ack,
    input  logic [INST_WIDTH-1:0]      imem_rdata,
    output logic                       if_valid,
    input  logic                       if_ready,
    output logic [INST_WIDTH-1:0]      if_inst,
    output logic [INST_ADDR_WIDTH-1:0] if_pc,
    output logic [2:0]                 fsm_state
);

    // Handshakes: imem_req stays high with imem_addr stable until the edge where imem_ack
    // is sampled high; if_valid stays high with if_inst/if_pc stable until the edge where
    // if_valid & if_ready is sampled high. All outputs are registered, so neither imem_req
    // nor if_valid depends combinationally on imem_ack or if_ready.
    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        FETCH   = 3'd1,
        WAIT    = 3'd2,
        DISCARD = 3'd3,
        HALTED  = 3'd4
    } state_t;

    state_t state;

    assign fsm_state = state;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            pc_out    <= RESET_PC;
            imem_req  <= 1'b0;
            imem_addr <= RESET_PC;
            if_valid  <= 1'b0;
            if_inst   <= '0;
            if_pc     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (halt) begin
                        state <= HALTED;
                    end else begin
                        state     <= FETCH;
                        imem_req  <= 1'b1;
                        imem_addr <= pc_out;
                    end
                end

                FETCH: begin
                    if (flush) begin
                        pc_out   <= pc_next;
                        if_valid <= 1'b0;
                        if (imem_ack) begin
                            // Read finished in the flush cycle: drop it and restart at the target.
                            if (halt) begin
                                state    <= HALTED;
                                imem_req <= 1'b0;
                            end else begin
                                imem_addr <= pc_next;
                            end
                        end else begin
                            state <= DISCARD;
                        end
                    end else if (imem_ack) begin
                        if_inst  <= imem_rdata;
                        if_pc    <= imem_addr;
                        if_valid <= 1'b1;
                        pc_out   <= pc_next;
                        imem_req <= 1'b0;
                        state    <= WAIT;
                    end
                end

                WAIT: begin
                    if (flush || if_ready) begin
                        if_valid <= 1'b0;
                        if (flush) pc_out <= pc_next;
                        if (halt) begin
                            state <= HALTED;
                        end else begin
                            state     <= FETCH;
                            imem_req  <= 1'b1;
                            imem_addr <= flush ? pc_next : pc_out;
                        end
                    end
                end

                DISCARD: begin
                    // Abandoned read stays on the bus until the memory acknowledges it.
                    if (flush) pc_out <= pc_next;
                    if (imem_ack) begin
                        if (halt) begin
                            state    <= HALTED;
                            imem_req <= 1'b0;
                        end else begin
                            state     <= FETCH;
                            imem_addr <= flush ? pc_next : pc_out;
                        end
                    end
                end

                HALTED: begin
                    if (flush) begin
                        pc_out   <= pc_next;
                        if_valid <= 1'b0;
                    end
                    if (!halt) begin
                        state     <= FETCH;
                        imem_req  <= 1'b1;
                        imem_addr <= flush ? pc_next : pc_out;
                    end
                end

                default: begin
                    state    <= IDLE;
                    imem_req <= 1'b0;
                    if_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_inst_fetch.sv
// Bench for inst_fetch: directed scenarios then random traffic, checked every cycle
// against a transaction-level model (outstanding read, buffered instruction, PC).
module tb_inst_fetch;

    logic        clk;
    logic        rst_n;
    logic [15:0] pc_out;
    logic [15:0] pc_next;
    logic        flush;
    logic        halt;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic        imem_ack;
    logic [15:0] imem_rdata;
    logic        if_valid;
    logic        if_ready;
    logic [15:0] if_inst;
    logic [15:0] if_pc;
    logic [2:0]  fsm_state;

    logic        ack_en;
    logic [15:0] target;

    int vectors;
    int miscompares;

    // Model state
    logic        m_boot;
    logic        m_out;
    logic        m_stale;
    logic [15:0] m_addr;
    logic        m_buf;
    logic [15:0] m_bpc;
    logic [15:0] m_binst;
    logic [15:0] m_pc;

    int          deliveries;
    logic [15:0] got_q[$];
    logic [15:0] exp_q[$];

    inst_fetch #(
        .INST_ADDR_WIDTH(16),
        .INST_WIDTH(16),
        .RESET_PC(16'h0000)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .pc_out(pc_out),
        .pc_next(pc_next),
        .flush(flush),
        .halt(halt),
        .imem_req(imem_req),
        .imem_addr(imem_addr),
        .imem_ack(imem_ack),
        .imem_rdata(imem_rdata),
        .if_valid(if_valid),
        .if_ready(if_ready),
        .if_inst(if_inst),
        .if_pc(if_pc),
        .fsm_state(fsm_state)
    );

    function automatic logic [15:0] mem_word(input logic [15:0] a);
        logic [15:0] p;
        p = a * 16'h9E37;
        return p ^ 16'h5A5A;
    endfunction

    // Environment: PC adder and a memory that acks when enabled.
    assign pc_next    = flush ? target : pc_out + 16'd2;
    assign imem_ack   = ack_en && imem_req;
    assign imem_rdata = mem_word(imem_addr);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_edge(input logic f, input logic [15:0] tgt, input logic h,
                              input logic rdy, input logic ae, input logic rst);
        logic m_ack;
        logic hs;
        m_ack = ae && m_out;
        hs    = m_buf && rdy;
        if (!rst) begin
            m_boot  = 1'b1;
            m_out   = 1'b0;
            m_stale = 1'b0;
            m_buf   = 1'b0;
            m_pc    = 16'h0000;
        end else if (m_boot) begin
            m_boot = 1'b0;
            if (!h) begin
                m_out  = 1'b1;
                m_addr = m_pc;
            end
        end else begin
            if (m_ack) begin
                if (!m_stale && !f) begin
                    m_buf   = 1'b1;
                    m_bpc   = m_addr;
                    m_binst = mem_word(m_addr);
                    m_pc    = m_pc + 16'd2;
                end
                m_out   = 1'b0;
                m_stale = 1'b0;
            end else if (hs) begin
                m_buf = 1'b0;
            end
            if (f) begin
                m_pc  = tgt;
                m_buf = 1'b0;
                if (m_out) m_stale = 1'b1;
            end
            if (!m_out && !m_buf && !h) begin
                m_out  = 1'b1;
                m_addr = m_pc;
            end
        end
    endtask

    // Apply one cycle of inputs, advance one clock edge, then compare against the model.
    task automatic step(input logic f, input logic [15:0] tgt, input logic h,
                        input logic rdy, input logic ae, input logic rst);
        flush    = f;
        target   = tgt;
        halt     = h;
        if_ready = rdy;
        ack_en   = ae;
        rst_n    = rst;
        #1;
        if (rst && if_valid && rdy && !f) begin
            deliveries++;
            got_q.push_back(if_pc);
        end
        model_edge(f, tgt, h, rdy, ae, rst);
        @(negedge clk);
        check("imem_req", {15'd0, imem_req}, {15'd0, m_out});
        check("pc_out", pc_out, m_pc);
        check("if_valid", {15'd0, if_valid}, {15'd0, m_buf});
        if (m_out) check("imem_addr", imem_addr, m_addr);
        if (m_buf) begin
            check("if_pc", if_pc, m_bpc);
            check("if_inst", if_inst, m_binst);
        end
    endtask

    initial begin
        logic [15:0] held_inst;
        vectors     = 0;
        miscompares = 0;
        deliveries  = 0;
        m_boot = 1'b1; m_out = 1'b0; m_stale = 1'b0; m_buf = 1'b0;
        m_addr = '0; m_bpc = '0; m_binst = '0; m_pc = '0;
        rst_n = 1'b0; flush = 1'b0; halt = 1'b0; if_ready = 1'b0;
        ack_en = 1'b0; target = '0;
        @(negedge clk);

        // Reset held two cycles
        step(0, 16'h0, 0, 0, 0, 0);
        step(0, 16'h0, 0, 0, 0, 0);
        check("rst_if_inst", if_inst, 16'h0000);
        check("rst_if_pc", if_pc, 16'h0000);
        check("rst_req", {15'd0, imem_req}, 16'h0000);
        step(0, 16'h0, 0, 1, 0, 1);
        check("boot_req", {15'd0, imem_req}, 16'h0001);
        check("boot_addr", imem_addr, 16'h0000);

        // Stream: one instruction per 2 cycles
        got_q.delete();
        deliveries = 0;
        for (int i = 0; i < 8; i++) step(0, 16'h0, 0, 1, 1, 1);
        exp_q = '{16'h0000, 16'h0002, 16'h0004, 16'h0006};
        check("stream_count", deliveries[15:0], 16'd4);
        for (int i = 0; i < 4; i++) begin
            if (i < got_q.size()) check("stream_pc", got_q[i], exp_q[i]);
            else check("stream_missing", 16'hDEAD, exp_q[i]);
        end

        // Backpressure at 0x8
        step(0, 16'h0, 0, 0, 1, 1);
        held_inst = if_inst;
        for (int i = 0; i < 5; i++) begin
            step(0, 16'h0, 0, 0, 1, 1);
            check("bp_inst_stable", if_inst, held_inst);
            check("bp_no_req", {15'd0, imem_req}, 16'h0000);
        end
        step(0, 16'h0, 0, 1, 1, 1);
        check("bp_next_addr", imem_addr, 16'h000A);

        // Flush during an unacknowledged read at 0xA
        step(1, 16'h0040, 0, 1, 0, 1);
        step(0, 16'h0, 0, 1, 0, 1);
        check("discard_addr_held", imem_addr, 16'h000A);
        step(0, 16'h0, 0, 1, 0, 1);
        step(0, 16'h0, 0, 1, 1, 1);
        check("after_flush_addr", imem_addr, 16'h0040);

        // Halt during a fetch: current read still delivered, then PC held
        step(0, 16'h0, 1, 0, 1, 1);
        check("halt_delivered_pc", if_pc, 16'h0040);
        step(0, 16'h0, 1, 1, 1, 1);
        for (int i = 0; i < 3; i++) step(0, 16'h0, 1, 1, 1, 1);
        check("halt_no_req", {15'd0, imem_req}, 16'h0000);
        check("halt_pc_held", pc_out, 16'h0042);
        step(0, 16'h0, 0, 1, 1, 1);
        check("resume_addr", imem_addr, 16'h0042);

        // Wrap from 0xFFFE to 0x0000, then reset during a request
        step(1, 16'hFFFE, 0, 1, 1, 1);
        step(0, 16'h0, 0, 1, 1, 1);
        check("wrap_pc", if_pc, 16'hFFFE);
        step(0, 16'h0, 0, 1, 1, 1);
        check("wrap_addr", imem_addr, 16'h0000);
        step(0, 16'h0, 0, 1, 0, 0);
        check("midrst_req", {15'd0, imem_req}, 16'h0000);
        check("midrst_pc", pc_out, 16'h0000);
        step(0, 16'h0, 0, 1, 0, 1);

        // Random traffic
        for (int i = 0; i < 600; i++) begin
            logic        r_f, r_h, r_rdy, r_ae, r_rst;
            logic [15:0] r_t;
            r_rst = ($urandom_range(0, 59) != 0);
            r_f   = ($urandom_range(0, 9) == 0);
            r_h   = ($urandom_range(0, 5) == 0);
            r_rdy = ($urandom_range(0, 9) < 6);
            r_ae  = ($urandom_range(0, 1) == 1);
            r_t   = 16'($urandom) & 16'hFFFE;
            step(r_f, r_t, r_h, r_rdy, r_ae, r_rst);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
